// File: rtl/coin_input_conditioner.sv
// Coin input conditioner: synchronizes and debounces three raw coin/button lines, then issues clean one-hot pulses.
// Latency: a clean press pulses its output DEBOUNCE_CYCLES+2 edges after the raw line is first sampled high.
// Backpressure: none; one event per channel is queued, and a further press on a pending channel is dropped and flagged.
module coin_input_conditioner #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int GAP             = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic a_raw,
   input  logic b_raw,
   input  logic c_raw,
   output logic A,
   output logic B,
   output logic C,
   output logic busy,
   output logic dropped
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PULSE = 2'd1,
      S_GAP   = 2'd2
   } state_t;

   // Bit 0 = A, bit 1 = B, bit 2 = C throughout.
   logic [2:0]    raw;
   logic [2:0]    sync1_q;
   logic [2:0]    sync_q;
   logic [2:0]    lvl_q, lvl_d;
   logic [CW-1:0] cnt_q [3];
   logic [CW-1:0] cnt_d [3];
   logic [2:0]    rise;
   logic [2:0]    pend_q, pend_d;
   logic [2:0]    clr;
   logic [2:0]    out_q, out_d;
   logic [3:0]    gap_q, gap_d;
   state_t        state_q, state_d;
   logic          busy_q;
   logic          drop_q, drop_d;

   assign raw = {c_raw, b_raw, a_raw};

   // Two-flop synchronizer per channel. The reset input is expected to be
   // deasserted synchronously to clk by the surrounding logic.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q <= '0;
         sync_q  <= '0;
      end else begin
         sync1_q <= raw;
         sync_q  <= sync1_q;
      end
   end

   // Debounce: the level flips on the DEBOUNCE_CYCLES-th consecutive differing sample; only 0->1 flips raise an event.
   always_comb begin
      lvl_d = lvl_q;
      rise  = '0;
      for (int i = 0; i < 3; i++) begin
         cnt_d[i] = '0;
         if (sync_q[i] != lvl_q[i]) begin
            if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
               lvl_d[i] = ~lvl_q[i];
               rise[i]  = ~lvl_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
   end

   // Debounce state registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lvl_q <= '0;
         for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
      end else begin
         lvl_q <= lvl_d;
         for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   // Pending bits: a new event wins over a same-edge issue clear; an event on an already-pending channel is lost.
   always_comb begin
      pend_d = (pend_q & ~clr) | rise;
      drop_d = |(rise & pend_q & ~clr);
   end

   // Issue FSM: pick one pending event (A > B > C), pulse it for one cycle, then hold off for GAP idle cycles.
   always_comb begin
      state_d = state_q;
      out_d   = '0;
      clr     = '0;
      gap_d   = gap_q;
      case (state_q)
         S_IDLE: begin
            if (|pend_q) begin
               state_d = S_PULSE;
               if (pend_q[0]) begin
                  out_d = 3'b001;
                  clr   = 3'b001;
               end else if (pend_q[1]) begin
                  out_d = 3'b010;
                  clr   = 3'b010;
               end else begin
                  out_d = 3'b100;
                  clr   = 3'b100;
               end
            end
         end
         S_PULSE: begin
            if (GAP == 0) begin
               state_d = S_IDLE;
            end else begin
               gap_d   = 4'(GAP);
               state_d = S_GAP;
            end
         end
         S_GAP: begin
            if (gap_q <= 4'd1) begin
               state_d = S_IDLE;
            end else begin
               gap_d = gap_q - 4'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // FSM, pending, output and status registers; busy is a registered decode of the pending/FSM state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         gap_q   <= '0;
         out_q   <= '0;
         pend_q  <= '0;
         drop_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         gap_q   <= gap_d;
         out_q   <= out_d;
         pend_q  <= pend_d;
         drop_q  <= drop_d;
         busy_q  <= (|pend_q) | (state_q != S_IDLE);
      end
   end

   assign A       = out_q[0];
   assign B       = out_q[1];
   assign C       = out_q[2];
   assign busy    = busy_q;
   assign dropped = drop_q;

endmodule

// File: tb/tb_coin_input_conditioner.sv
// Directed bench for coin_input_conditioner using three instances:
// d0 = defaults (DEBOUNCE_CYCLES=4, GAP=1), d1 = GAP=3, d2 = DEBOUNCE_CYCLES=1/GAP=0.
// All instances share clock, reset and raw lines; each scenario checks the relevant instance.
module tb_coin_input_conditioner;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       a_raw, b_raw, c_raw;
   logic [2:0] a_o, b_o, c_o, busy_o, drop_o;

   int n_cmp  = 0;
   int n_fail = 0;

   coin_input_conditioner #(.DEBOUNCE_CYCLES(4), .GAP(1)) u_def (
      .clk(clk), .rst(rst), .a_raw(a_raw), .b_raw(b_raw), .c_raw(c_raw),
      .A(a_o[0]), .B(b_o[0]), .C(c_o[0]), .busy(busy_o[0]), .dropped(drop_o[0])
   );

   coin_input_conditioner #(.DEBOUNCE_CYCLES(4), .GAP(3)) u_g3 (
      .clk(clk), .rst(rst), .a_raw(a_raw), .b_raw(b_raw), .c_raw(c_raw),
      .A(a_o[1]), .B(b_o[1]), .C(c_o[1]), .busy(busy_o[1]), .dropped(drop_o[1])
   );

   coin_input_conditioner #(.DEBOUNCE_CYCLES(1), .GAP(0)) u_fast (
      .clk(clk), .rst(rst), .a_raw(a_raw), .b_raw(b_raw), .c_raw(c_raw),
      .A(a_o[2]), .B(b_o[2]), .C(c_o[2]), .busy(busy_o[2]), .dropped(drop_o[2])
   );

   task automatic chk(input string tag, input logic obs, input logic exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
      end
   endtask

   task automatic chk_out(input string tag, input int d,
                          input logic ea, input logic eb, input logic ec, input logic ed);
      chk({tag, "_A"}, a_o[d], ea);
      chk({tag, "_B"}, b_o[d], eb);
      chk({tag, "_C"}, c_o[d], ec);
      chk({tag, "_drop"}, drop_o[d], ed);
   endtask

   // One clock: drive raw lines at the falling edge, sample 1 time unit after the rising edge.
   task automatic tick(input logic a, input logic b, input logic c);
      @(negedge clk);
      a_raw = a;
      b_raw = b;
      c_raw = c;
      @(posedge clk);
      #1;
   endtask

   task automatic reset_all();
      @(negedge clk);
      rst   = 1'b0;
      a_raw = 1'b0;
      b_raw = 1'b0;
      c_raw = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (2) tick(1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      rst   = 1'b1;
      a_raw = 1'b0;
      b_raw = 1'b0;
      c_raw = 1'b0;
      #1 rst = 1'b0;

      // Reset held while raw lines toggle: every output stays low.
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         {c_raw, b_raw, a_raw} = 3'(i + 1);
         @(posedge clk);
         #1;
         for (int d = 0; d < 3; d++) begin
            chk_out($sformatf("rst_d%0d_c%0d", d, i), d, 1'b0, 1'b0, 1'b0, 1'b0);
            chk($sformatf("rst_d%0d_c%0d_busy", d, i), busy_o[d], 1'b0);
         end
      end
      @(negedge clk);
      {c_raw, b_raw, a_raw} = 3'b000;
      rst = 1'b1;
      repeat (3) tick(1'b0, 1'b0, 1'b0);

      // Single press held high: A between E6 and E7, busy after E6..E8, exactly one pulse.
      for (int n = 0; n < 12; n++) begin
         tick(1'b1, 1'b0, 1'b0);
         chk_out($sformatf("press_e%0d", n), 0, (n == 6), 1'b0, 1'b0, 1'b0);
         chk($sformatf("press_e%0d_busy", n), busy_o[0], (n >= 6 && n <= 8));
      end
      for (int n = 0; n < 10; n++) begin
         tick(1'b0, 1'b0, 1'b0);
         chk_out($sformatf("release_e%0d", n), 0, 1'b0, 1'b0, 1'b0, 1'b0);
      end

      // Bounce on b: three single-cycle glitches two cycles apart never produce a pulse.
      for (int g = 0; g < 3; g++) begin
         tick(1'b0, 1'b1, 1'b0);
         chk_out($sformatf("glitch%0d_hi", g), 0, 1'b0, 1'b0, 1'b0, 1'b0);
         for (int k = 0; k < 2; k++) begin
            tick(1'b0, 1'b0, 1'b0);
            chk_out($sformatf("glitch%0d_lo%0d", g, k), 0, 1'b0, 1'b0, 1'b0, 1'b0);
         end
      end
      for (int n = 0; n < 4; n++) begin
         tick(1'b0, 1'b0, 1'b0);
         chk_out($sformatf("glitch_settle%0d", n), 0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      // Then a 10-cycle hold gives one B pulse at E6.
      for (int n = 0; n < 10; n++) begin
         tick(1'b0, 1'b1, 1'b0);
         chk_out($sformatf("bhold_e%0d", n), 0, 1'b0, (n == 6), 1'b0, 1'b0);
      end
      for (int n = 0; n < 10; n++) begin
         tick(1'b0, 1'b0, 1'b0);
         chk_out($sformatf("brel_e%0d", n), 0, 1'b0, 1'b0, 1'b0, 1'b0);
      end

      // Simultaneous presses, GAP=1: A at E6, B at E9, C at E12.
      reset_all();
      for (int n = 0; n < 15; n++) begin
         tick(1'b1, 1'b1, 1'b1);
         chk_out($sformatf("simul_e%0d", n), 0, (n == 6), (n == 9), (n == 12), 1'b0);
      end
      for (int n = 0; n < 12; n++) tick(1'b0, 1'b0, 1'b0);

      // GAP=3: A,B,C pressed together; c released and re-pressed while pend_c is still set.
      // Pulses at E6/E11/E16, re-press debounces at E14 and is dropped.
      reset_all();
      for (int n = 0; n < 25; n++) begin
         tick(1'b1, 1'b1, (n <= 4) || (n >= 9));
         chk_out($sformatf("drop_e%0d", n), 1, (n == 6), (n == 11), (n == 16), (n == 14));
      end

      // Reset between E5 and E6 with pend_a set: no A, busy low; re-release with a held high gives one A.
      reset_all();
      for (int n = 0; n < 6; n++) begin
         tick(1'b1, 1'b0, 1'b0);
         chk_out($sformatf("mid_e%0d", n), 0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      #2;
      rst = 1'b0;
      #1;
      chk_out("mid_rst", 0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("mid_rst_busy", busy_o[0], 1'b0);
      for (int n = 0; n < 2; n++) begin
         tick(1'b1, 1'b0, 1'b0);
         chk_out($sformatf("mid_hold%0d", n), 0, 1'b0, 1'b0, 1'b0, 1'b0);
         chk($sformatf("mid_hold%0d_busy", n), busy_o[0], 1'b0);
      end
      @(negedge clk);
      rst   = 1'b1;
      a_raw = 1'b1;
      @(posedge clk);
      #1;
      chk_out("rerel_e0", 0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int n = 1; n < 11; n++) begin
         tick(1'b1, 1'b0, 1'b0);
         chk_out($sformatf("rerel_e%0d", n), 0, (n == 6), 1'b0, 1'b0, 1'b0);
         chk($sformatf("rerel_e%0d_busy", n), busy_o[0], (n >= 6 && n <= 8));
      end

      // DEBOUNCE_CYCLES=1, GAP=0: 4-high/4-low presses, one A per press 3 edges after the rising sample.
      reset_all();
      for (int p = 0; p < 3; p++) begin
         for (int k = 0; k < 8; k++) begin
            tick((k < 4), 1'b0, 1'b0);
            chk_out($sformatf("fast_p%0d_k%0d", p, k), 2, (k == 3), 1'b0, 1'b0, 1'b0);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
